// File: rtl/traffic_scheduler_pkg.sv
// Shared definitions for the intersection phase scheduler.
//
// Contents:
//   phase_t          - encoded phase of the scheduler state register
//   DEFAULT_*        - default phase lengths in clock cycles
//   maxLen()         - largest of the five phase lengths, sizes the phase timer
//   isGreenPhase()   - true for the two vehicle green phases
//
// The walk phases are always part of the encoding. They are only reachable
// when the scheduler is built with PEDESTRIAN_WALK_EN defined.
package traffic_scheduler_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        WALK_A    = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        ALL_RED_B = 3'd6,
        WALK_B    = 3'd7
    } phase_t;

    localparam int DEFAULT_GREEN_CYCLES     = 8;
    localparam int DEFAULT_MIN_GREEN_CYCLES = 3;
    localparam int DEFAULT_YELLOW_CYCLES    = 2;
    localparam int DEFAULT_ALL_RED_CYCLES   = 1;
    localparam int DEFAULT_WALK_CYCLES      = 4;

    function automatic int maxLen(input int a, input int b, input int c,
                                  input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    function automatic logic isGreenPhase(input phase_t p);
        return (p == NS_GREEN) || (p == EW_GREEN);
    endfunction

endpackage

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Phase timer for the intersection scheduler.
//
// Counts 0, 1, 2, ... from the cycle a phase is entered. tc_o flags the
// last cycle of the phase, when the count equals last_i.
//
// Ports:
//   clk_i    - clock, rising edge
//   reset_i  - synchronous active-high reset, count returns to 0
//   load_i   - restart the count at 0 on this edge (phase transition)
//   last_i   - final count value of the current phase (length - 1)
//   count_o  - cycles already spent in the current phase
//   tc_o     - terminal count, current cycle is the last of the phase
import traffic_scheduler_pkg::*;

module phase_timer #(
    parameter int CW = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          load_i,
    input  logic [CW-1:0] last_i,
    output logic [CW-1:0] count_o,
    output logic          tc_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The count restarts on every phase change, including an early green end,
    // so the owner decides when to load rather than relying on tc_o alone.
    always_comb begin
        count_d = count_q + CW'(1);
        if (load_i) begin
            count_d = '0;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == last_i);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase scheduler.
//
// Cycles NS_GREEN -> NS_YELLOW -> ALL_RED_A -> EW_GREEN -> EW_YELLOW ->
// ALL_RED_B -> NS_GREEN. Every lamp and walk output is decoded from the
// state register only.
//
// Build option PEDESTRIAN_WALK_EN: a crossing request is latched. A green
// that has lasted at least MIN_GREEN_CYCLES then ends early. The next
// all-red exit then enters a walk phase with every lamp red. Without the
// macro the buttons are ignored and walk_active stays 0.
//
// Ports:
//   clock_signal                  - clock, all state changes on rising edge
//   reset_signal                  - synchronous active-high reset to ALL_RED_B
//   ns_pedestrian_button_pressed  - north-south crossing request (level)
//   ew_pedestrian_button_pressed  - east-west crossing request (level)
//   ns_*_light_active             - north-south red/yellow/green lamps
//   ew_*_light_active             - east-west red/yellow/green lamps
//   walk_active                   - pedestrian walk indication
//   current_phase                 - encoded phase_t of the state register
import traffic_scheduler_pkg::*;

module intersection_phase_scheduler #(
    parameter int GREEN_CYCLES     = DEFAULT_GREEN_CYCLES,
    parameter int MIN_GREEN_CYCLES = DEFAULT_MIN_GREEN_CYCLES,
    parameter int YELLOW_CYCLES    = DEFAULT_YELLOW_CYCLES,
    parameter int ALL_RED_CYCLES   = DEFAULT_ALL_RED_CYCLES,
    parameter int WALK_CYCLES      = DEFAULT_WALK_CYCLES
) (
    input  logic       clock_signal,
    input  logic       reset_signal,
    input  logic       ns_pedestrian_button_pressed,
    input  logic       ew_pedestrian_button_pressed,
    output logic       ns_red_light_active,
    output logic       ns_yellow_light_active,
    output logic       ns_green_light_active,
    output logic       ew_red_light_active,
    output logic       ew_yellow_light_active,
    output logic       ew_green_light_active,
    output logic       walk_active,
    output logic [2:0] current_phase
);

    localparam int MAX_LEN = maxLen(GREEN_CYCLES, MIN_GREEN_CYCLES, YELLOW_CYCLES,
                                    ALL_RED_CYCLES, WALK_CYCLES);
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] GREEN_LAST     = CW'(GREEN_CYCLES - 1);
    localparam logic [CW-1:0] MIN_GREEN_LAST = CW'(MIN_GREEN_CYCLES - 1);
    localparam logic [CW-1:0] YELLOW_LAST    = CW'(YELLOW_CYCLES - 1);
    localparam logic [CW-1:0] ALL_RED_LAST   = CW'(ALL_RED_CYCLES - 1);
    localparam logic [CW-1:0] WALK_LAST      = CW'(WALK_CYCLES - 1);

    phase_t        state_q;
    phase_t        state_d;
    logic          advance;
    logic          earlyEnd;
    logic          walkRequest;
    logic [CW-1:0] phaseLast;
    logic [CW-1:0] timerCount;
    logic          timerTc;

    phase_timer #(
        .CW(CW)
    ) uPhaseTimer (
        .clk_i   (clock_signal),
        .reset_i (reset_signal),
        .load_i  (advance),
        .last_i  (phaseLast),
        .count_o (timerCount),
        .tc_o    (timerTc)
    );

    // Final count value of the phase currently held in the state register.
    always_comb begin
        phaseLast = ALL_RED_LAST;
        case (state_q)
            NS_GREEN, EW_GREEN:   phaseLast = GREEN_LAST;
            NS_YELLOW, EW_YELLOW: phaseLast = YELLOW_LAST;
            WALK_A, WALK_B:       phaseLast = WALK_LAST;
            default:              phaseLast = ALL_RED_LAST;
        endcase
    end

    // Next-state logic. A phase ends at its terminal count. A green can also
    // end early on a pedestrian request, so advance also drives the timer
    // reload.
    always_comb begin
        state_d = state_q;
        advance = timerTc | earlyEnd;
        if (advance) begin
            case (state_q)
                NS_GREEN:  state_d = NS_YELLOW;
                NS_YELLOW: state_d = ALL_RED_A;
                ALL_RED_A: state_d = walkRequest ? WALK_A : EW_GREEN;
                WALK_A:    state_d = EW_GREEN;
                EW_GREEN:  state_d = EW_YELLOW;
                EW_YELLOW: state_d = ALL_RED_B;
                ALL_RED_B: state_d = walkRequest ? WALK_B : NS_GREEN;
                WALK_B:    state_d = NS_GREEN;
                default:   state_d = ALL_RED_B;
            endcase
        end
    end

    // State register. Reset lands in the clearance phase before NS_GREEN, so
    // the first green follows one full all-red interval.
    always_ff @(posedge clock_signal) begin
        if (reset_signal) begin
            state_q <= ALL_RED_B;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PEDESTRIAN_WALK_EN
    logic pending_q;
    logic pending_d;
    logic inWalk;
    logic enterWalk;

    assign inWalk    = (state_q == WALK_A) || (state_q == WALK_B);
    assign enterWalk = advance && ((state_d == WALK_A) || (state_d == WALK_B));

    // Request latch. Presses during a walk are not recorded. The clear on walk
    // entry overrides a press on the same edge, so that press counts as
    // served by the walk being entered.
    always_comb begin
        pending_d = pending_q;
        if (!inWalk) begin
            pending_d = pending_q | ns_pedestrian_button_pressed
                                  | ew_pedestrian_button_pressed;
        end
        if (enterWalk) begin
            pending_d = 1'b0;
        end
    end

    // Pending-request register with synchronous reset.
    always_ff @(posedge clock_signal) begin
        if (reset_signal) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign walkRequest = pending_q;
    assign earlyEnd    = isGreenPhase(state_q) && pending_q && (timerCount >= MIN_GREEN_LAST);
    assign walk_active = inWalk;
`else
    logic unusedInputs;

    assign walkRequest  = 1'b0;
    assign earlyEnd     = 1'b0;
    assign walk_active  = 1'b0;
    assign unusedInputs = ^{ns_pedestrian_button_pressed, ew_pedestrian_button_pressed,
                            timerCount, MIN_GREEN_LAST};
`endif

    // Moore lamp decode. Both roads show red by default, which also covers
    // the all-red and walk phases.
    always_comb begin
        ns_red_light_active    = 1'b1;
        ns_yellow_light_active = 1'b0;
        ns_green_light_active  = 1'b0;
        ew_red_light_active    = 1'b1;
        ew_yellow_light_active = 1'b0;
        ew_green_light_active  = 1'b0;
        case (state_q)
            NS_GREEN: begin
                ns_red_light_active   = 1'b0;
                ns_green_light_active = 1'b1;
            end
            NS_YELLOW: begin
                ns_red_light_active    = 1'b0;
                ns_yellow_light_active = 1'b1;
            end
            EW_GREEN: begin
                ew_red_light_active   = 1'b0;
                ew_green_light_active = 1'b1;
            end
            EW_YELLOW: begin
                ew_red_light_active    = 1'b0;
                ew_yellow_light_active = 1'b1;
            end
            default: begin
                ns_red_light_active = 1'b1;
                ew_red_light_active = 1'b1;
            end
        endcase
    end

    assign current_phase = state_q;

endmodule

// File: doc/intersection_phase_scheduler.md
INTERSECTION_PHASE_SCHEDULER -- requirements
Module: intersection_phase_scheduler

Interface
REQ-001 Parameter GREEN_CYCLES, 8, full green phase length in clocks.
REQ-002 Parameter MIN_GREEN_CYCLES, 3, minimum green before a pedestrian request may end green early.
REQ-003 Parameter YELLOW_CYCLES, 2, yellow phase length.
REQ-004 Parameter ALL_RED_CYCLES, 1, clearance phase length.
REQ-005 Parameter WALK_CYCLES, 4, pedestrian walk phase length.
REQ-006 clock_signal  input  1  single clock; all state changes on its rising edge.
REQ-007 reset_signal  input  1  synchronous, active-high reset.
REQ-008 ns_pedestrian_button_pressed  input  1  north-south crossing request, level, sampled every edge.
REQ-009 ew_pedestrian_button_pressed  input  1  east-west crossing request, level, sampled every edge.
REQ-010 ns_red/ns_yellow/ns_green_light_active  output  1 each  north-south lamps.
REQ-011 ew_red/ew_yellow/ew_green_light_active  output  1 each  east-west lamps.
REQ-012 walk_active  output  1  pedestrian walk indication.
REQ-013 current_phase  output  3  encoded phase_t of the state register.

Function
REQ-014 States: ALL_RED_B -> NS_GREEN -> NS_YELLOW -> ALL_RED_A -> [WALK_A] -> EW_GREEN -> EW_YELLOW -> ALL_RED_B -> [WALK_B] -> NS_GREEN.
REQ-015 Phase timer counts 0..N-1 in each state; transition occurs on the edge where count == N-1; count returns to 0 on every transition.
REQ-016 Outputs are Moore decodes of the state register only; no input-to-output combinational path.
REQ-017 Each direction has exactly one lamp active per cycle; at most one direction is non-red in any cycle.
REQ-018 WALK_A/WALK_B: all lamps red, walk_active=1; every other state walk_active=0.
REQ-019 Either button high latches ped_pending; set and hold have priority over nothing except clear.
REQ-020 In a GREEN state with ped_pending=1 and count >= MIN_GREEN_CYCLES-1, green ends on that edge (early yellow).
REQ-021 On leaving ALL_RED_A/ALL_RED_B with ped_pending=1, enter the WALK state; otherwise enter the next GREEN.
REQ-022 ped_pending clears on entry to WALK; a press coincident with the entry edge is absorbed (served); presses during WALK are ignored.
REQ-023 A press during YELLOW or ALL_RED is latched and served at the next ALL_RED exit.
REQ-024 Parameters SHALL satisfy 1 <= MIN_GREEN_CYCLES <= GREEN_CYCLES, all lengths >= 1; counter width is $clog2 of the largest length +1.

Reset
REQ-025 reset_signal high at an edge: state=ALL_RED_B, count=0, ped_pending=0, from any state, mid-phase included.
REQ-026 During/after reset: all lamps red, walk_active=0, current_phase=ALL_RED_B; first NS_GREEN begins ALL_RED_CYCLES edges after reset deasserts.

Configuration
REQ-027 Macro PEDESTRIAN_WALK_EN defined: REQ-018..023 in force.
REQ-028 Macro absent: buttons ignored, no ped_pending or WALK states, walk_active tied 0, greens always run GREEN_CYCLES.

Structure
REQ-029 Package traffic_scheduler_pkg holds phase_t enum and default length constants.
REQ-030 Sub-module phase_timer (load/count/terminal-count) is instantiated once.

Verification
REQ-031 Defaults, no presses, 44 clocks after reset: NS_GREEN 8, NS_YELLOW 2, ALL_RED_A 1, EW_GREEN 8, EW_YELLOW 2, ALL_RED_B 1; 22-cycle period repeats.
REQ-032 NS press on NS_GREEN count 1: green lasts 3 cycles, then yellow 2, all-red 1, WALK_A 4 with walk_active=1, then EW_GREEN.
REQ-033 EW press during EW_YELLOW: EW_YELLOW unchanged, WALK_B follows ALL_RED_B, then NS_GREEN full 8.
REQ-034 Both buttons pressed same cycle, and again during WALK: single WALK served, no second WALK next cycle.
REQ-035 Reset asserted mid-EW_GREEN with ped_pending=1: next edge all red, current_phase=ALL_RED_B, pending cleared, no WALK after.
REQ-036 Every cycle, assertion: one lamp per direction, never both directions non-red; build without PEDESTRIAN_WALK_EN shows walk_active=0 and REQ-031 timing under presses.
